// File: rtl/pool_pkg.sv
// ---------------------------------------------------------------------------
// pool_pkg
//  Shared definitions for the pooling / upsampling datapath.
//  - Mode encoding shared with the max-pool compare stage
//    (00 inactive, 01 x2, 11 x3, 10 reserved and treated as inactive).
//  - Default pixel width.
//  - Control state enumeration used by the upsampler FSM.
//  - mode_factor(): maps a mode code to its replication factor
//    (0 for the inactive / reserved codes).
// ---------------------------------------------------------------------------
package pool_pkg;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_X2  = 2'b01;
  localparam logic [1:0] MODE_RSV = 2'b10;
  localparam logic [1:0] MODE_X3  = 2'b11;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    EMIT = 2'b10
  } state_t;

  // Replication factor for a mode code; the reserved code behaves like OFF.
  function automatic logic [1:0] mode_factor(input logic [1:0] mode);
    logic [1:0] fac;
    case (mode)
      MODE_X2: fac = 2'd2;
      MODE_X3: fac = 2'd3;
      default: fac = 2'd0;
    endcase
    return fac;
  endfunction

endpackage

// File: rtl/upsample_replicator_line_buf.sv
// ---------------------------------------------------------------------------
// line_buf
//  Single-row line buffer: DEPTH entries of DW bits, one write port and one
//  registered read port with a read enable. When rd_en is low the read
//  register keeps its value, which lets the upsampler use it as the first
//  stage of a stallable output pipeline.
//  Ports:
//   clk      in   1    rising-edge clock
//   wr_en    in   1    write strobe
//   wr_addr  in   AW   write address
//   wr_data  in   DW   write data
//   rd_en    in   1    read strobe (loads the read register)
//   rd_addr  in   AW   read address
//   rd_data  out  DW   registered read data
//  Storage is intentionally not reset: contents are don't-care until written.
// ---------------------------------------------------------------------------
module line_buf
  import pool_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] rd_data_d;

  // Read-register next value: load on rd_en, otherwise hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/upsample_replicator.sv
// ---------------------------------------------------------------------------
// upsample_replicator
//  Nearest-neighbour upsampler for feature-map rows. One input row of ROW_W
//  pixels is captured into a line buffer, then replayed with every pixel
//  repeated FACTOR times horizontally and the whole row FACTOR times
//  vertically (FACTOR 2 or 3, chosen by mode while idle).
//  Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   mode       in   2    00/10 inactive, 01 x2, 11 x3; sampled only in IDLE
//   in_data    in   DW   input pixel
//   in_valid   in   1    input pixel valid
//   in_ready   out  1    block accepts in_data this cycle (LOAD)
//   out_data   out  DW   output pixel (registered)
//   out_valid  out  1    output pixel valid (registered)
//   out_ready  in   1    downstream accepts out_data
//   out_last   out  1    final beat of each output row
//   busy       out  1    high in LOAD or EMIT
//
//  Output path is a two-stage pipeline:
//   stage 1 = line-buffer read register (s1_*), held while it cannot drain,
//   stage 2 = output register (out_*), held while out_valid & !out_ready.
//  Reads are only issued when stage 1 has room, so a downstream stall never
//  drops or repeats a beat, and with out_ready held high the pipeline
//  streams one beat per cycle.
// ---------------------------------------------------------------------------
module upsample_replicator
  import pool_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int ROW_W = 16,
  parameter int AW    = (ROW_W > 1) ? $clog2(ROW_W) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy
);

  localparam logic [AW-1:0] COL_MAX = AW'(ROW_W - 1);

  // Control state and counters.
  state_t        state_q, state_d;
  logic [1:0]    fac_q, fac_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] col_q, col_d;
  logic [1:0]    rep_h_q, rep_h_d;
  logic [1:0]    rep_v_q, rep_v_d;
  logic          issue_done_q, issue_done_d;

  // Stage 1 side-band (data lives in the line-buffer read register).
  logic          s1_vld_q, s1_vld_d;
  logic          s1_last_q, s1_last_d;
  logic          s1_final_q, s1_final_d;

  // Stage 2 / output register.
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic          out_final_q, out_final_d;

  // Registered status outputs.
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;

  logic [1:0]    fac_m1;
  logic          in_fire;
  logic          out_fire;
  logic          adv2;
  logic          s1_ready;
  logic          issue;
  logic          beat_last;
  logic          beat_final;
  logic [DW-1:0] rd_data;

  assign fac_m1     = fac_q - 2'd1;
  assign in_fire    = in_valid & in_ready_q;
  assign out_fire   = out_valid_q & out_ready;
  // Output register may load when empty or when its beat is leaving.
  assign adv2       = ~out_valid_q | out_ready;
  // Read register may load when empty or when it drains into stage 2.
  assign s1_ready   = ~s1_vld_q | adv2;
  assign issue      = (state_q == EMIT) & ~issue_done_q & s1_ready;
  assign beat_last  = (col_q == COL_MAX) & (rep_h_q == fac_m1);
  assign beat_final = beat_last & (rep_v_q == fac_m1);

  line_buf #(
    .DW    (DW),
    .DEPTH (ROW_W),
    .AW    (AW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (in_fire),
    .wr_addr (wr_ptr_q),
    .wr_data (in_data),
    .rd_en   (issue),
    .rd_addr (col_q),
    .rd_data (rd_data)
  );

  // FSM next state, factor latch, write pointer and read-address counters.
  always_comb begin
    state_d      = state_q;
    fac_d        = fac_q;
    wr_ptr_d     = wr_ptr_q;
    col_d        = col_q;
    rep_h_d      = rep_h_q;
    rep_v_d      = rep_v_q;
    issue_done_d = issue_done_q;

    case (state_q)
      IDLE: begin
        if ((mode == MODE_X2) || (mode == MODE_X3)) begin
          fac_d   = mode_factor(mode);
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end

      LOAD: begin
        if (in_fire) begin
          if (wr_ptr_q == COL_MAX) begin
            wr_ptr_d = {AW{1'b0}};
            state_d  = EMIT;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end

      EMIT: begin
        // Address generation runs ahead of the output by the pipeline depth;
        // it stops after issuing the final beat and waits for it to drain.
        if (issue) begin
          if (beat_final) begin
            col_d        = {AW{1'b0}};
            rep_h_d      = 2'd0;
            rep_v_d      = 2'd0;
            issue_done_d = 1'b1;
          end else if (rep_h_q == fac_m1) begin
            rep_h_d = 2'd0;
            if (col_q == COL_MAX) begin
              col_d   = {AW{1'b0}};
              rep_v_d = rep_v_q + 2'd1;
            end else begin
              col_d = col_q + AW'(1);
            end
          end else begin
            rep_h_d = rep_h_q + 2'd1;
          end
        end else begin
          col_d = col_q;
        end

        if (out_fire && out_final_q) begin
          issue_done_d = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = EMIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output pipeline next values: stage 1 side-band and output register.
  always_comb begin
    s1_vld_d    = s1_vld_q;
    s1_last_d   = s1_last_q;
    s1_final_d  = s1_final_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_final_d = out_final_q;

    if (issue) begin
      s1_vld_d   = 1'b1;
      s1_last_d  = beat_last;
      s1_final_d = beat_final;
    end else if (adv2) begin
      s1_vld_d   = 1'b0;
      s1_last_d  = 1'b0;
      s1_final_d = 1'b0;
    end else begin
      s1_vld_d = s1_vld_q;
    end

    if (adv2) begin
      out_valid_d = s1_vld_q;
      if (s1_vld_q) begin
        out_data_d  = rd_data;
        out_last_d  = s1_last_q;
        out_final_d = s1_final_q;
      end else begin
        out_last_d  = 1'b0;
        out_final_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end

    in_ready_d = (state_d == LOAD);
    busy_d     = (state_d != IDLE);
  end

  // Control state, counters and factor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fac_q        <= 2'd0;
      wr_ptr_q     <= {AW{1'b0}};
      col_q        <= {AW{1'b0}};
      rep_h_q      <= 2'd0;
      rep_v_q      <= 2'd0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fac_q        <= fac_d;
      wr_ptr_q     <= wr_ptr_d;
      col_q        <= col_d;
      rep_h_q      <= rep_h_d;
      rep_v_q      <= rep_v_d;
      issue_done_q <= issue_done_d;
    end
  end

  // Output pipeline and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_final_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {DW{1'b0}};
      out_last_q  <= 1'b0;
      out_final_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_final_q  <= s1_final_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_final_q <= out_final_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_upsample_replicator.sv
// ---------------------------------------------------------------------------
// Testbench for upsample_replicator (ROW_W = 4, DW = 32).
// Expected beats come from a reference model that simply expands the input
// row with nested loops (rows x pixels x horizontal repeats). Inputs are
// driven on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_upsample_replicator;

  localparam int DW    = 32;
  localparam int ROW_W = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    mode;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] row_px [ROW_W];

  upsample_replicator #(
    .DW    (DW),
    .ROW_W (ROW_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, DW'(out_valid), '0);
    check({tag, "_out_data"},  out_data,       '0);
    check({tag, "_out_last"},  DW'(out_last),  '0);
    check({tag, "_in_ready"},  DW'(in_ready),  '0);
    check({tag, "_busy"},      DW'(busy),      '0);
  endtask

  // One full frame: load row_px with mode m, collect and compare all beats.
  // m_mid replaces mode once output starts; abort_beat >= 0 pulls reset
  // while that beat index is being presented.
  task automatic run_frame(input string tag, input logic [1:0] m, input logic [1:0] m_mid,
                           input int rdy_pct, input int gap_pct, input int abort_beat);
    beat_t         exp_q[$];
    int            f;
    int            n_exp;
    int            n_last_exp;
    int            idx;
    int            nbeats;
    int            nlast;
    int            cyc;
    int            fire_cyc;
    int            first_cyc;
    logic          stalled;
    logic [DW-1:0] held_d;
    logic          held_l;
    beat_t         b;

    f = (m == 2'b11) ? 3 : 2;
    for (int r = 0; r < f; r++)
      for (int c = 0; c < ROW_W; c++)
        for (int h = 0; h < f; h++)
          exp_q.push_back('{d: row_px[c], l: (c == ROW_W - 1) && (h == f - 1)});
    n_exp      = exp_q.size();
    n_last_exp = f;
    idx = 0; nbeats = 0; nlast = 0; cyc = 0;
    fire_cyc = -1; first_cyc = -1;
    stalled = 1'b0; held_d = '0; held_l = 1'b0;
    mode = m;

    while (cyc < 3000 && exp_q.size() != 0) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check({tag, "_stall_valid"}, DW'(out_valid), DW'(1));
        check({tag, "_stall_data"},  out_data,       held_d);
        check({tag, "_stall_last"},  DW'(out_last),  DW'(held_l));
      end
      if (out_valid && first_cyc < 0) begin
        first_cyc = cyc;
        check({tag, "_latency"}, DW'(first_cyc - fire_cyc), DW'(3));
        mode = m_mid;
      end
      if (abort_beat >= 0 && nbeats == abort_beat && out_valid) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs({tag, "_abort"});
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mode      = 2'b00;
        @(negedge clk);
        check({tag, "_abort_hold_busy"}, DW'(busy), '0);
        rst_n = 1'b1;
        return;
      end

      out_ready = ($urandom_range(99) < rdy_pct);
      if (idx < ROW_W) begin
        in_valid = ($urandom_range(99) >= gap_pct);
        in_data  = in_valid ? row_px[idx] : DW'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && in_ready) begin
        idx++;
        if (idx == ROW_W) fire_cyc = cyc;
      end

      if (out_valid && out_ready) begin
        b = exp_q.pop_front();
        check({tag, "_data"}, out_data,      b.d);
        check({tag, "_last"}, DW'(out_last), DW'(b.l));
        nbeats++;
        if (out_last) nlast++;
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
    end

    mode     = 2'b00;
    in_valid = 1'b0;
    check({tag, "_left_over"}, DW'(exp_q.size()), '0);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_beats"},     DW'(nbeats),   DW'(n_exp));
    check({tag, "_lasts"},     DW'(nlast),    DW'(n_last_exp));
    check({tag, "_end_valid"}, DW'(out_valid), '0);
    check({tag, "_end_busy"},  DW'(busy),      '0);
    @(negedge clk);
    check({tag, "_idle_busy"},  DW'(busy),     '0);
    check({tag, "_idle_ready"}, DW'(in_ready), '0);
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 2'b00;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // 1) x2, 1..4, always ready
    for (int i = 0; i < ROW_W; i++) row_px[i] = DW'(i + 1);
    run_frame("x2_basic", 2'b01, 2'b01, 100, 0, -1);

    // 2) x3, A..D
    for (int i = 0; i < ROW_W; i++) row_px[i] = DW'(10 + i);
    run_frame("x3_basic", 2'b11, 2'b11, 100, 0, -1);

    // 3) x2 with random back-pressure and input gaps
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < ROW_W; i++) row_px[i] = DW'($urandom);
      run_frame("x2_stall", 2'b01, 2'b01, 50, 30, -1);
    end
    for (int i = 0; i < ROW_W; i++) row_px[i] = DW'($urandom);
    run_frame("x3_stall", 2'b11, 2'b11, 50, 30, -1);

    // 4) inactive and reserved modes with in_valid held high
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mode = (k == 0) ? 2'b00 : 2'b10;
      for (int c = 0; c < 20; c++) begin
        in_data = DW'($urandom);
        @(negedge clk);
        check("off_in_ready",  DW'(in_ready),  '0);
        check("off_out_valid", DW'(out_valid), '0);
        check("off_busy",      DW'(busy),      '0);
      end
    end
    in_valid = 1'b0;
    mode     = 2'b00;
    @(negedge clk);

    // 5) mode switched to x3 during EMIT: frame stays x2, next frame is x3
    for (int i = 0; i < ROW_W; i++) row_px[i] = DW'($urandom);
    run_frame("x2_modechg", 2'b01, 2'b11, 100, 0, -1);
    for (int i = 0; i < ROW_W; i++) row_px[i] = DW'($urandom);
    run_frame("x3_after_chg", 2'b11, 2'b11, 100, 0, -1);

    // 6) reset during the fifth beat, then a clean x2 frame 9,8,7,6
    for (int i = 0; i < ROW_W; i++) row_px[i] = DW'($urandom);
    run_frame("abort", 2'b01, 2'b01, 100, 0, 4);
    for (int i = 0; i < ROW_W; i++) row_px[i] = DW'(9 - i);
    run_frame("post_abort", 2'b01, 2'b01, 100, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
